// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl: synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, a hysteretic pause back-pressure output and sticky error flags.
// Ports:
//   clk, reset (async, active-low)
//   Fifo_wr / Fifo_rd / Fifo_Data_in                : write/read requests and write data
//   umbral_alto / umbral_bajo                       : pause assert / release thresholds
//   Fifo_Data_out / Fifo_valid                      : registered read data, one-cycle valid
//   fifo_count, fifo_empty, fifo_full               : occupancy and its flags
//   almost_full, almost_empty                       : threshold compares on fifo_count
//   pause                                           : advisory back-pressure to the writer
//   error_overflow / error_underflow                : sticky until reset
module fifo_flow_ctrl #(
   parameter int unsigned BITNUMBER = 8,
   parameter int unsigned LENGTH    = 8,
   parameter int unsigned ADDR      = $clog2(LENGTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Fifo_wr,
   input  logic                 Fifo_rd,
   input  logic [BITNUMBER-1:0] Fifo_Data_in,
   input  logic [ADDR:0]        umbral_alto,
   input  logic [ADDR:0]        umbral_bajo,
   output logic [BITNUMBER-1:0] Fifo_Data_out,
   output logic                 Fifo_valid,
   output logic [ADDR:0]        fifo_count,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 pause,
   output logic                 error_overflow,
   output logic                 error_underflow
);

   localparam int unsigned CW = ADDR + 1;

   typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} pause_state_t;

   logic [BITNUMBER-1:0] mem [LENGTH];
   logic [ADDR-1:0]      wr_ptr;
   logic [ADDR-1:0]      rd_ptr;
   logic                 wr_acc;
   logic                 rd_acc;
   logic [ADDR:0]        count_next;
   pause_state_t         state;
   pause_state_t         state_next;

   // Status flags decode the registered count
   assign fifo_empty   = (fifo_count == '0);
   assign fifo_full    = (fifo_count == CW'(LENGTH));
   assign almost_full  = (fifo_count >= umbral_alto);
   assign almost_empty = (fifo_count <= umbral_bajo);
   assign pause        = (state == ST_PAUSE);

   // A write into a full FIFO is allowed when a read frees a slot in the same cycle
   assign wr_acc     = Fifo_wr && (!fifo_full || Fifo_rd);
   assign rd_acc     = Fifo_rd && !fifo_empty;
   assign count_next = fifo_count + CW'(wr_acc) - CW'(rd_acc);

   // Storage array; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= Fifo_Data_in;
      end
   end

   // Pointers, count, read data and sticky errors
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_count      <= '0;
         Fifo_Data_out   <= '0;
         Fifo_valid      <= 1'b0;
         error_overflow  <= 1'b0;
         error_underflow <= 1'b0;
      end else begin
         fifo_count <= count_next;
         Fifo_valid <= rd_acc;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ADDR'(1);
         end
         if (rd_acc) begin
            rd_ptr        <= rd_ptr + ADDR'(1);
            Fifo_Data_out <= mem[rd_ptr];
         end
         if (Fifo_wr && !wr_acc) begin
            error_overflow <= 1'b1;
         end
         if (Fifo_rd && !rd_acc) begin
            error_underflow <= 1'b1;
         end
      end
   end

   // Pause state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Pause next-state: hysteresis between thresholds, plain compare when they overlap
   always_comb begin
      state_next = state;
      if (umbral_bajo >= umbral_alto) begin
         state_next = (count_next >= umbral_alto) ? ST_PAUSE : ST_RUN;
      end else begin
         case (state)
            ST_RUN:   if (count_next >= umbral_alto) state_next = ST_PAUSE;
            ST_PAUSE: if (count_next <= umbral_bajo) state_next = ST_RUN;
            default:  state_next = ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Testbench for fifo_flow_ctrl: directed stimulus with a scoreboard of expected read data
// checked by an independent monitor, plus direct checks of count, flags, pause and errors.
module tb_fifo_flow_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       Fifo_wr;
   logic       Fifo_rd;
   logic [7:0] Fifo_Data_in;
   logic [3:0] umbral_alto;
   logic [3:0] umbral_bajo;
   logic [7:0] Fifo_Data_out;
   logic       Fifo_valid;
   logic [3:0] fifo_count;
   logic       fifo_empty;
   logic       fifo_full;
   logic       almost_full;
   logic       almost_empty;
   logic       pause;
   logic       error_overflow;
   logic       error_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q [$];   // expected read data, in order
   logic [7:0] ref_q [$];   // bench's view of FIFO contents

   fifo_flow_ctrl #(.BITNUMBER(8), .LENGTH(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .Fifo_wr         (Fifo_wr),
      .Fifo_rd         (Fifo_rd),
      .Fifo_Data_in    (Fifo_Data_in),
      .umbral_alto     (umbral_alto),
      .umbral_bajo     (umbral_bajo),
      .Fifo_Data_out   (Fifo_Data_out),
      .Fifo_valid      (Fifo_valid),
      .fifo_count      (fifo_count),
      .fifo_empty      (fifo_empty),
      .fifo_full       (fifo_full),
      .almost_full     (almost_full),
      .almost_empty    (almost_empty),
      .pause           (pause),
      .error_overflow  (error_overflow),
      .error_underflow (error_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the expected read word is queued when the read will be accepted
   task automatic cyc(input logic wr, input logic rd, input logic [7:0] d);
      bit rd_ok;
      bit wr_ok;
      rd_ok = rd && (ref_q.size() > 0);
      wr_ok = wr && ((ref_q.size() < 8) || rd);
      if (rd_ok) exp_q.push_back(ref_q.pop_front());
      if (wr_ok) ref_q.push_back(d);
      Fifo_wr      = wr;
      Fifo_rd      = rd;
      Fifo_Data_in = d;
      @(posedge clk);
      #1;
      Fifo_wr = 1'b0;
      Fifo_rd = 1'b0;
   endtask

   // Monitor: every valid output word must match the head of the scoreboard
   always @(negedge clk) begin
      if (reset === 1'b1 && Fifo_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no valid output", Fifo_Data_out);
         end else begin
            chk("rd_data", int'(Fifo_Data_out), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      Fifo_wr      = 1'b0;
      Fifo_rd      = 1'b0;
      Fifo_Data_in = 8'h00;
      umbral_alto  = 4'd6;
      umbral_bajo  = 4'd2;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", fifo_count, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_aempty", almost_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_pause", pause, 0);
      chk("rst_valid", Fifo_valid, 0);
      chk("rst_errs", {error_overflow, error_underflow}, 0);
      reset = 1'b1;

      // 1: four writes, one read
      cyc(1, 0, 8'h0A); cyc(1, 0, 8'h0B); cyc(1, 0, 8'h0C); cyc(1, 0, 8'h0D);
      chk("t1_count4", fifo_count, 4);
      cyc(0, 1, 8'h00);
      chk("t1_valid", Fifo_valid, 1);
      chk("t1_data", Fifo_Data_out, 8'h0A);
      chk("t1_count3", fifo_count, 3);
      chk("t1_errs", {error_overflow, error_underflow}, 0);
      cyc(0, 0, 8'h00);
      chk("t1_valid_pulse", Fifo_valid, 0);
      repeat (3) cyc(0, 1, 8'h00);
      chk("t1_empty", fifo_empty, 1);

      // 2: overfill, then drain in order
      for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
      chk("t2_full", fifo_full, 1);
      chk("t2_count8", fifo_count, 8);
      chk("t2_ovf_clear", error_overflow, 0);
      cyc(1, 0, 8'h09);
      chk("t2_ovf", error_overflow, 1);
      chk("t2_count_hold", fifo_count, 8);
      for (int i = 1; i <= 8; i++) cyc(0, 1, 8'h00);
      chk("t2_empty", fifo_empty, 1);
      chk("t2_pause_rel", pause, 0);

      // 3: pause hysteresis
      for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h30 + i));
      chk("t3_pause_at5", pause, 0);
      cyc(1, 0, 8'h35);
      chk("t3_pause_at6", pause, 1);
      chk("t3_afull", almost_full, 1);
      repeat (3) cyc(0, 1, 8'h00);
      chk("t3_count3", fifo_count, 3);
      chk("t3_pause_hold", pause, 1);
      cyc(0, 1, 8'h00);
      chk("t3_pause_rel", pause, 0);
      chk("t3_aempty", almost_empty, 1);
      cyc(1, 0, 8'h36); cyc(1, 0, 8'h37); cyc(1, 0, 8'h38);
      chk("t3_count5", fifo_count, 5);
      chk("t3_pause_low", pause, 0);
      chk("t3_afull_low", almost_full, 0);
      repeat (5) cyc(0, 1, 8'h00);
      chk("t3_empty", fifo_empty, 1);

      // 4: simultaneous rd+wr while full, then streaming with wrap
      for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h40 + i));
      cyc(1, 1, 8'hF0);
      chk("t4_count", fifo_count, 8);
      chk("t4_full", fifo_full, 1);
      chk("t4_data", Fifo_Data_out, 8'h40);
      for (int i = 0; i < 16; i++) cyc(1, 1, 8'(8'h50 + i));
      chk("t4_stream_count", fifo_count, 8);
      repeat (8) cyc(0, 1, 8'h00);
      chk("t4_last", Fifo_Data_out, 8'h5F);
      chk("t4_empty", fifo_empty, 1);
      chk("t4_unf_clear", error_underflow, 0);

      // 5: reads while empty
      cyc(0, 1, 8'h00);
      chk("t5_unf", error_underflow, 1);
      chk("t5_valid", Fifo_valid, 0);
      chk("t5_hold", Fifo_Data_out, 8'h5F);
      cyc(1, 1, 8'h77);
      chk("t5_count1", fifo_count, 1);
      chk("t5_valid_rw", Fifo_valid, 0);
      chk("t5_hold_rw", Fifo_Data_out, 8'h5F);
      cyc(0, 1, 8'h00);
      chk("t5_data", Fifo_Data_out, 8'h77);

      // 6: asynchronous reset mid-fill
      for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'h60 + i));
      cyc(0, 1, 8'h00);
      cyc(0, 0, 8'h00);
      chk("t6_count5", fifo_count, 5);
      chk("t6_pause", pause, 1);
      #2;
      reset = 1'b0;
      #1;
      ref_q.delete();
      chk("t6_count0", fifo_count, 0);
      chk("t6_pause0", pause, 0);
      chk("t6_empty", fifo_empty, 1);
      chk("t6_full0", fifo_full, 0);
      chk("t6_dout0", Fifo_Data_out, 0);
      chk("t6_errs0", {error_overflow, error_underflow}, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(1, 0, 8'h11);
      cyc(0, 1, 8'h00);
      chk("t6_readback", Fifo_Data_out, 8'h11);

      // Degenerate and extreme thresholds
      umbral_alto = 4'd2;
      umbral_bajo = 4'd3;
      cyc(1, 0, 8'h21);
      chk("dg_pause_c1", pause, 0);
      cyc(1, 0, 8'h22);
      chk("dg_pause_c2", pause, 1);
      cyc(1, 0, 8'h23);
      chk("dg_pause_c3", pause, 1);
      umbral_alto = 4'd0;
      umbral_bajo = 4'd0;
      repeat (3) cyc(0, 1, 8'h00);
      chk("dg_alto0", pause, 1);
      umbral_alto = 4'd9;
      umbral_bajo = 4'd2;
      cyc(0, 0, 8'h00);
      chk("dg_alto9", pause, 0);

      repeat (2) cyc(0, 0, 8'h00);
      chk("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
